branch_predictor_gshare_btb: RTL and testbench

Parametrised successor to the core's gshare predictor. It adds a tagged branch target buffer (BTB), a configurable global history register (GHR) and a return address stack (RAS).
- Sits in the fetch stage: a combinational prediction for PCF each cycle.
- Trained non-speculatively from the execute stage with the resolved outcome.
- Drop-in for the core: prediction interface unchanged; update interface extended with an instruction-class field.

---
 rtl/branch_predictor_gshare_btb_pkg.sv | 15 +
 rtl/branch_predictor_gshare_btb_return_address_stack.sv | 46 ++++
 rtl/branch_predictor_gshare_btb.sv | 135 +++++++++++++
 tb/tb_branch_predictor_gshare_btb.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/branch_predictor_gshare_btb_pkg.sv
// Shared encodings and widths for the gshare + BTB + RAS branch predictor.
package branch_predictor_gshare_btb_pkg;

  localparam int BTB_TYPE_W = 2;

  typedef logic [BTB_TYPE_W-1:0] upd_type_t;

  localparam upd_type_t UPD_COND = 2'b00;
  localparam upd_type_t UPD_JUMP = 2'b01;
  localparam upd_type_t UPD_CALL = 2'b10;
  localparam upd_type_t UPD_RET  = 2'b11;

  localparam logic [1:0] PHT_RESET = 2'b01;

endpackage

// File: rtl/branch_predictor_gshare_btb_return_address_stack.sv
// Circular return address stack: pushes overwrite the oldest entry when full,
// pops on an empty stack are ignored.
module return_address_stack #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [XLEN-1:0]            push_addr,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  stack [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_ptr;

  // ptr addresses the next free slot; the newest entry sits just below it
  assign top_ptr = ptr - PTR_W'(1);
  assign top     = stack[top_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH))
        count <= count + CNT_W'(1);
    end else if (pop && (count != '0)) begin
      ptr   <= top_ptr;
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      stack[ptr] <= push_addr;
  end

endmodule

// File: rtl/branch_predictor_gshare_btb.sv
// Fetch-stage branch predictor: gshare direction, tagged direct-mapped BTB and
// a return address stack, trained from the execute stage.
module branch_predictor_gshare_btb
  import branch_predictor_gshare_btb_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int HIST_BITS   = 8,
  parameter int BTB_ENTRIES = 64,
  parameter int TAG_BITS    = 12,
  parameter int RAS_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] PCPrediction,
  output logic            predTaken,
  input  logic            we,
  input  logic [XLEN-1:0] PCUpdate,
  input  logic [XLEN-1:0] targetUpdate,
  input  logic            takenUpdate,
  input  logic [1:0]      updType
);

  localparam int IDX_W       = $clog2(BTB_ENTRIES);
  localparam int PHT_ENTRIES = 1 << HIST_BITS;
  localparam int RAS_CNT_W   = $clog2(RAS_DEPTH) + 1;

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    if (taken)
      return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else
      return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  logic [HIST_BITS-1:0]     ghr;
  logic [2*PHT_ENTRIES-1:0] pht;
  logic [BTB_ENTRIES-1:0]   btb_valid;
  logic [TAG_BITS-1:0]      btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]          btb_target [BTB_ENTRIES];
  upd_type_t                btb_type   [BTB_ENTRIES];

  logic [HIST_BITS-1:0] pht_idx_f, pht_idx_u;
  logic [IDX_W-1:0]     btb_idx_f, btb_idx_u;
  logic [TAG_BITS-1:0]  tag_f, tag_u;
  logic                 hit_f;
  upd_type_t            type_f;

  logic                 ras_push, ras_pop;
  logic [XLEN-1:0]      ras_top;
  logic [RAS_CNT_W-1:0] ras_count;
  logic                 unused_ok;

  // Only a slice of each PC feeds the index/tag fields
  assign unused_ok = ^{PC, PCUpdate};

  // Fetch: index/tag extraction and BTB lookup
  assign pht_idx_f = PC[HIST_BITS+1:2] ^ ghr;
  assign btb_idx_f = PC[IDX_W+1:2];
  assign tag_f     = PC[IDX_W+TAG_BITS+1:IDX_W+2];
  assign hit_f     = btb_valid[btb_idx_f] && (btb_tag[btb_idx_f] == tag_f);
  assign type_f    = btb_type[btb_idx_f];

  always_comb begin
    PCPrediction = PCPlus4;
    predTaken    = 1'b0;
    if (hit_f) begin
      case (type_f)
        UPD_JUMP, UPD_CALL: begin
          PCPrediction = btb_target[btb_idx_f];
          predTaken    = 1'b1;
        end
        UPD_COND: begin
          if (pht[{pht_idx_f, 1'b1}]) begin
            PCPrediction = btb_target[btb_idx_f];
            predTaken    = 1'b1;
          end
        end
        UPD_RET: begin
          if (ras_count != '0) begin
            PCPrediction = ras_top;
            predTaken    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Execute: training from the resolved instruction
  assign pht_idx_u = PCUpdate[HIST_BITS+1:2] ^ ghr;
  assign btb_idx_u = PCUpdate[IDX_W+1:2];
  assign tag_u     = PCUpdate[IDX_W+TAG_BITS+1:IDX_W+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr       <= '0;
      pht       <= {PHT_ENTRIES{PHT_RESET}};
      btb_valid <= '0;
    end else if (we) begin
      if (updType == UPD_COND) begin
        pht[{pht_idx_u, 1'b0} +: 2] <= sat_ctr(pht[{pht_idx_u, 1'b0} +: 2], takenUpdate);
        ghr <= {ghr[HIST_BITS-2:0], takenUpdate};
      end
      if (takenUpdate)
        btb_valid[btb_idx_u] <= 1'b1;
    end
  end

  // Payload is only meaningful behind a valid bit, so it carries no reset
  always_ff @(posedge clk) begin
    if (we && takenUpdate) begin
      btb_tag[btb_idx_u]    <= tag_u;
      btb_target[btb_idx_u] <= targetUpdate;
      btb_type[btb_idx_u]   <= updType;
    end
  end

  assign ras_push = we && (updType == UPD_CALL);
  assign ras_pop  = we && (updType == UPD_RET);

  return_address_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_addr (PCUpdate + XLEN'(4)),
    .top       (ras_top),
    .count     (ras_count)
  );

endmodule

// File: tb/tb_branch_predictor_gshare_btb.sv
// Directed bench for branch_predictor_gshare_btb with hand-computed expectations.
module tb_branch_predictor_gshare_btb;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] PC, PCPlus4, PCPrediction, PCUpdate, targetUpdate;
  logic        predTaken, we, takenUpdate;
  logic [1:0]  updType;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] COND = 2'b00, JUMP = 2'b01, CALL = 2'b10, RET = 2'b11;

  branch_predictor_gshare_btb dut (
    .clk          (clk),
    .reset        (reset),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .PCPrediction (PCPrediction),
    .predTaken    (predTaken),
    .we           (we),
    .PCUpdate     (PCUpdate),
    .targetUpdate (targetUpdate),
    .takenUpdate  (takenUpdate),
    .updType      (updType)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pred(input string tag, input logic [63:0] pc,
                      input logic [63:0] exp_pc, input logic exp_tk);
    @(negedge clk);
    PC = pc; PCPlus4 = pc + 64'd4;
    #1;
    chk({tag, "_pc"}, PCPrediction, exp_pc);
    chk({tag, "_tk"}, {63'd0, predTaken}, {63'd0, exp_tk});
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt,
                     input logic tk, input logic [1:0] ty);
    @(negedge clk);
    we = 1'b1; PCUpdate = pc; targetUpdate = tgt; takenUpdate = tk; updType = ty;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; PCUpdate = '0; targetUpdate = '0;
    takenUpdate = 1'b0; updType = COND; PC = 64'h1000; PCPlus4 = 64'h1004;

    // Reset behaviour
    pred("rst_hold", 64'h1000, 64'h1004, 1'b0);
    @(posedge clk); #1; reset = 1'b0;
    pred("rst_first", 64'h1000, 64'h1004, 1'b0);
    upd(64'h1000, 64'h1800, 1'b1, JUMP);
    pred("jmp1000", 64'h1000, 64'h1800, 1'b1);

    // Reset asserted in the middle of an update cycle
    @(negedge clk);
    we = 1'b1; PCUpdate = 64'h1000; targetUpdate = 64'h1900; takenUpdate = 1'b1; updType = JUMP;
    PC = 64'h1000; PCPlus4 = 64'h1004;
    #2; reset = 1'b1; #1;
    chk("rst_mid_pc", PCPrediction, 64'h1004);
    @(posedge clk); #1;
    reset = 1'b0; we = 1'b0;
    pred("rst_mid_after", 64'h1000, 64'h1004, 1'b0);

    // Conditional branch at 0x2000; GHR climbs 00,01,03,...,FF then holds at FF
    for (int k = 1; k <= 11; k++) begin
      upd(64'h2000, 64'h2400, 1'b1, COND);
      if (k == 2)  pred("cond_t2",  64'h2000, 64'h2004, 1'b0);
      if (k == 8)  pred("cond_t8",  64'h2000, 64'h2004, 1'b0);
      if (k == 9)  pred("cond_t9",  64'h2000, 64'h2400, 1'b1);
      if (k == 10) pred("cond_t10", 64'h2000, 64'h2400, 1'b1);
      if (k == 11) pred("cond_sat11", 64'h2000, 64'h2400, 1'b1);
    end
    // GHR falls back to 00; pht[0] goes 10 -> 01 -> 00 -> 00
    for (int k = 1; k <= 11; k++) begin
      upd(64'h2000, 64'h2004, 1'b0, COND);
      if (k == 3)  pred("cond_nt3",    64'h2000, 64'h2004, 1'b0);
      if (k == 10) pred("cond_nt10",   64'h2000, 64'h2004, 1'b0);
      if (k == 11) pred("cond_sat00",  64'h2000, 64'h2004, 1'b0);
    end

    // Jump at 0x3000 trained while the same PC is being predicted
    @(negedge clk);
    PC = 64'h3000; PCPlus4 = 64'h3004;
    we = 1'b1; PCUpdate = 64'h3000; targetUpdate = 64'h3800; takenUpdate = 1'b1; updType = JUMP;
    #1;
    chk("jmp_same_old", PCPrediction, 64'h3004);
    @(posedge clk); #1;
    we = 1'b0;
    chk("jmp_same_new", PCPrediction, 64'h3800);
    pred("jmp_alias", 64'h3100, 64'h3104, 1'b0);
    @(negedge clk);
    PC = 64'h3000; PCPlus4 = 64'h3004;
    we = 1'b1; PCUpdate = 64'h3000; targetUpdate = 64'h3C00; takenUpdate = 1'b1; updType = JUMP;
    #1;
    chk("jmp_repl_old", PCPrediction, 64'h3800);
    @(posedge clk); #1;
    we = 1'b0;
    chk("jmp_repl_new", PCPrediction, 64'h3C00);
    upd(64'h3100, 64'h3900, 1'b1, JUMP);
    pred("jmp_tagrepl", 64'h3100, 64'h3900, 1'b1);
    pred("jmp_evicted", 64'h3000, 64'h3004, 1'b0);

    // Call / return
    upd(64'h4000, 64'h5000, 1'b1, CALL);
    pred("call_hit", 64'h4000, 64'h5000, 1'b1);
    upd(64'h5010, 64'h4004, 1'b1, RET);
    upd(64'h4000, 64'h5000, 1'b1, CALL);
    pred("ret_hit", 64'h5010, 64'h4004, 1'b1);
    upd(64'h5010, 64'h4004, 1'b1, RET);
    pred("ret_empty", 64'h5010, 64'h5014, 1'b0);
    upd(64'h5010, 64'h4004, 1'b1, RET);
    pred("ret_empty2", 64'h5010, 64'h5014, 1'b0);

    // RAS overflow: nine calls, 0x104 is overwritten
    for (int i = 1; i <= 9; i++)
      upd(64'(i) * 64'h100, 64'h5000, 1'b1, CALL);
    for (int k = 0; k < 8; k++) begin
      pred($sformatf("ras_pop%0d", k), 64'h5010, 64'h904 - 64'(k) * 64'h100, 1'b1);
      upd(64'h5010, 64'h4004, 1'b1, RET);
    end
    pred("ras_drained", 64'h5010, 64'h5014, 1'b0);
    upd(64'h5010, 64'h4004, 1'b1, RET);
    pred("ras_pop9", 64'h5010, 64'h5014, 1'b0);
    upd(64'h0A00, 64'h5000, 1'b1, CALL);
    pred("ras_repush", 64'h5010, 64'h0A04, 1'b1);

    // Global history: alternating T/NT from a clean reset
    pulse_reset();
    for (int k = 0; k < 8; k++)
      upd(64'h6000, (k % 2 == 0) ? 64'h6100 : 64'h6004, (k % 2 == 0), COND);
    chk("ghr_alt", {56'd0, dut.ghr}, 64'hAA);
    pred("ghr_alt_pred", 64'h6000, 64'h6004, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
